// File: rtl/ts_rcv_chk_pkg.sv
// ts_rcv_chk_pkg
//   Shared constants and types for the receive-side TS checker: ordered-set
//   symbols, LTSSM state/substate codes, consecutive-TS targets, port mode
//   codes, the TS type and handoff-state enums, and a symbol extractor.
package ts_rcv_chk_pkg;

  // Ordered-set symbols
  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] PADG12    = 8'hF7;
  localparam logic [7:0] TS1_IDTFR = 8'h4A;
  localparam logic [7:0] TS2_IDTFR = 8'h45;

  // Port orientation
  localparam logic DSP = 1'b0;
  localparam logic USP = 1'b1;

  // LTSSM states (ts_info[7:4])
  localparam logic [3:0] ST_DETECT = 4'h0;
  localparam logic [3:0] ST_POLL   = 4'h1;
  localparam logic [3:0] ST_CFG    = 4'h2;
  localparam logic [3:0] ST_L0     = 4'h3;

  // Polling substates (ts_info[3:0])
  localparam logic [3:0] SUB_POLL_ACTIVE = 4'h0;
  localparam logic [3:0] SUB_POLL_CFG    = 4'h1;

  // Configuration substates (ts_info[3:0])
  localparam logic [3:0] SUB_CFG_LW_START = 4'h0;
  localparam logic [3:0] SUB_CFG_LW_ACC   = 4'h1;
  localparam logic [3:0] SUB_CFG_LN_WAIT  = 4'h2;
  localparam logic [3:0] SUB_CFG_LN_ACC   = 4'h3;
  localparam logic [3:0] SUB_CFG_COMPLETE = 4'h4;
  localparam logic [3:0] SUB_CFG_IDLE     = 4'h5;

  // Consecutive-TS targets
  localparam logic [7:0] RX_NUM_POLL_ACT2CFG = 8'd8;
  localparam logic [7:0] RX_NUM_CFG_C2I      = 8'd8;
  localparam logic [7:0] RX_NUM_CFG_GENERAL  = 8'd2;

  typedef enum logic [1:0] {
    TS_NONE = 2'b00,
    TS_TS1  = 2'b01,
    TS_TS2  = 2'b10
  } ts_type_e;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'b00,
    HS_LINK_VLD = 2'b01,
    HS_LANE_VLD = 2'b10
  } hs_state_e;

  // Symbol idx of a TS word; symbol0 sits in the top byte.
  function automatic logic [7:0] ts_sym(input logic [127:0] ts, input int idx);
    return ts[127-8*idx -: 8];
  endfunction

endpackage

// File: rtl/ts_rcv_chk_if.sv
// ts_rcv_chk_if
//   RX TS bus from the lane receive path plus the handoff signals shared
//   with the TS generator.
//   master: drives rx_ts_valid/rx_ts, to_tsa_ts_sent_enough, to_tsa_update_ack
//   slave : the checker; drives from_tsa_rcv_link/lane_num and their vld levels
interface ts_rcv_chk_if;
  logic         rx_ts_valid;
  logic [127:0] rx_ts;
  logic         to_tsa_ts_sent_enough;
  logic         to_tsa_update_ack;
  logic [7:0]   from_tsa_rcv_link_num;
  logic         from_tsa_rcv_link_num_vld;
  logic [7:0]   from_tsa_rcv_lane_num;
  logic         from_tsa_rcv_lane_num_vld;

  modport master (
    output rx_ts_valid, rx_ts, to_tsa_ts_sent_enough, to_tsa_update_ack,
    input  from_tsa_rcv_link_num, from_tsa_rcv_link_num_vld,
           from_tsa_rcv_lane_num, from_tsa_rcv_lane_num_vld
  );

  modport slave (
    input  rx_ts_valid, rx_ts, to_tsa_ts_sent_enough, to_tsa_update_ack,
    output from_tsa_rcv_link_num, from_tsa_rcv_link_num_vld,
           from_tsa_rcv_lane_num, from_tsa_rcv_lane_num_vld
  );
endinterface

// File: rtl/ts_rcv_chk_rx_decode.sv
// ts_rcv_chk_rx_decode
//   Combinational TS classifier.
//   rx_ts     in  128  one TS word, symbol0 in [127:120]
//   ts_type   out 2    TS1 / TS2 / none (bad COM or mixed identifiers)
//   rate      out 6    symbol4[5:0]
//   match_fld out 40   symbols 1..5 (link, lane, n_fts, rate, train ctrl)
module ts_rcv_chk_rx_decode
  import ts_rcv_chk_pkg::*;
(
  input  logic [127:0] rx_ts,
  output ts_type_e     ts_type,
  output logic [5:0]   rate,
  output logic [39:0]  match_fld
);

  logic all_ts1_s;
  logic all_ts2_s;

  // Classify: identifiers in symbols 6..15 must all agree on one TS type.
  always_comb begin
    all_ts1_s = 1'b1;
    all_ts2_s = 1'b1;
    for (int i = 6; i < 16; i++) begin
      all_ts1_s = all_ts1_s & (ts_sym(rx_ts, i) == TS1_IDTFR);
      all_ts2_s = all_ts2_s & (ts_sym(rx_ts, i) == TS2_IDTFR);
    end
    if (ts_sym(rx_ts, 0) != COM) begin
      ts_type = TS_NONE;
    end else if (all_ts1_s) begin
      ts_type = TS_TS1;
    end else if (all_ts2_s) begin
      ts_type = TS_TS2;
    end else begin
      ts_type = TS_NONE;
    end
  end

  assign rate      = rx_ts[93:88];
  assign match_fld = rx_ts[119:80];

endmodule

// File: rtl/ts_rcv_chk.sv
// ts_rcv_chk
//   Receive-side TS checker/analyzer for one lane. Stage 1 registers the
//   decoded TS, stage 2 counts consecutive identical TSs and checks the count
//   against the LTSSM state; a small FSM hands received Link/Lane numbers to
//   the generator in USP mode.
//   clk, rst_n         clock, async active-low reset
//   ts_info            [7:4] LTSSM state, [3:0] substate
//   ts_info_update     pulse: state changed, clears count and handoff
//   mode               DSP / USP
//   bus (slave)        RX TS word and generator handoff
//   rx_ts_type         type of last accepted TS (00 none/invalid)
//   rx_consec_cnt      consecutive identical TS count, saturating
//   rx_rate            symbol4[5:0] of last valid TS
//   rcv_enough         count reached target with expected type
//   ready_to_advance   rcv_enough & generator sent enough
module ts_rcv_chk
  import ts_rcv_chk_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ts_info,
  input  logic             ts_info_update,
  input  logic             mode,
  ts_rcv_chk_if.slave      bus,
  output logic [1:0]       rx_ts_type,
  output logic [CNT_W-1:0] rx_consec_cnt,
  output logic [5:0]       rx_rate,
  output logic             rcv_enough,
  output logic             ready_to_advance
);

  // Decoder outputs
  ts_type_e    dec_type_s;
  logic [5:0]  dec_rate_s;
  logic [39:0] dec_match_s;

  // Stage 1
  logic        s1_vld_r;
  ts_type_e    s1_type_r;
  logic [5:0]  s1_rate_r;
  logic [39:0] s1_match_r;

  // Stage 2 state
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  ts_type_e         prev_type_r, prev_type_nxt_s;
  logic [39:0]      prev_match_r, prev_match_nxt_s;
  ts_type_e         type_r, type_nxt_s;
  logic [5:0]       rate_r, rate_nxt_s;
  logic             rcv_enough_r, ready_r;

  // Target selection
  logic [7:0] tgt_s;
  logic       tgt_en_s, ok_ts1_s, ok_ts2_s, type_ok_s, enough_nxt_s;

  // Handoff FSM
  hs_state_e  hs_state_r;
  logic [7:0] link_num_r, lane_num_r;
  logic       link_vld_r, lane_vld_r, link_done_r, lane_done_r;
  logic       lw_sub_s, ln_sub_s, cnt_ge2_s, link_go_s, lane_go_s;
  logic [7:0] prev_sym1_s, prev_sym2_s;

  ts_rcv_chk_rx_decode u_decode (
    .rx_ts     (bus.rx_ts),
    .ts_type   (dec_type_s),
    .rate      (dec_rate_s),
    .match_fld (dec_match_s)
  );

  // Stage 1: register the decoded TS when the RX path presents one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r   <= 1'b0;
      s1_type_r  <= TS_NONE;
      s1_rate_r  <= 6'd0;
      s1_match_r <= 40'd0;
    end else begin
      s1_vld_r <= bus.rx_ts_valid;
      if (bus.rx_ts_valid) begin
        s1_type_r  <= dec_type_s;
        s1_rate_r  <= dec_rate_s;
        s1_match_r <= dec_match_s;
      end
    end
  end

  // Stage 2 next state: a state change clears the count and wins over a TS
  // arriving in the same cycle.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    prev_type_nxt_s  = prev_type_r;
    prev_match_nxt_s = prev_match_r;
    type_nxt_s       = type_r;
    rate_nxt_s       = rate_r;
    if (ts_info_update) begin
      cnt_nxt_s        = '0;
      prev_type_nxt_s  = TS_NONE;
      prev_match_nxt_s = 40'd0;
    end else if (s1_vld_r) begin
      if (s1_type_r == TS_NONE) begin
        cnt_nxt_s        = '0;
        prev_type_nxt_s  = TS_NONE;
        prev_match_nxt_s = 40'd0;
        type_nxt_s       = TS_NONE;
      end else if ((s1_type_r == prev_type_r) && (s1_match_r == prev_match_r)) begin
        // prev_type_r is TS_NONE after a clear, so a cleared prev never matches
        cnt_nxt_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        type_nxt_s = s1_type_r;
        rate_nxt_s = s1_rate_r;
      end else begin
        cnt_nxt_s        = CNT_W'(1);
        prev_type_nxt_s  = s1_type_r;
        prev_match_nxt_s = s1_match_r;
        type_nxt_s       = s1_type_r;
        rate_nxt_s       = s1_rate_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Target count and accepted TS type for the current LTSSM state.
  always_comb begin
    tgt_s    = 8'd0;
    tgt_en_s = 1'b0;
    ok_ts1_s = 1'b0;
    ok_ts2_s = 1'b0;
    case (ts_info[7:4])
      ST_POLL: begin
        case (ts_info[3:0])
          SUB_POLL_ACTIVE: begin
            tgt_en_s = 1'b1; ok_ts1_s = 1'b1; ok_ts2_s = 1'b1;
            tgt_s    = RX_NUM_POLL_ACT2CFG;
          end
          SUB_POLL_CFG: begin
            tgt_en_s = 1'b1; ok_ts2_s = 1'b1;
            tgt_s    = RX_NUM_POLL_ACT2CFG;
          end
          default: tgt_en_s = 1'b0;
        endcase
      end
      ST_CFG: begin
        case (ts_info[3:0])
          SUB_CFG_COMPLETE, SUB_CFG_IDLE: begin
            tgt_en_s = 1'b1; ok_ts2_s = 1'b1;
            tgt_s    = RX_NUM_CFG_C2I;
          end
          default: begin
            tgt_en_s = 1'b1; ok_ts1_s = 1'b1;
            tgt_s    = RX_NUM_CFG_GENERAL;
          end
        endcase
      end
      default: tgt_en_s = 1'b0;
    endcase
    type_ok_s    = ((prev_type_nxt_s == TS_TS1) && ok_ts1_s) ||
                   ((prev_type_nxt_s == TS_TS2) && ok_ts2_s);
    enough_nxt_s = tgt_en_s && type_ok_s && (cnt_nxt_s >= CNT_W'(tgt_s));
  end

  // Stage 2 registers; rcv_enough is computed from next-state values so it
  // lands in the same cycle as the count it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      prev_type_r  <= TS_NONE;
      prev_match_r <= 40'd0;
      type_r       <= TS_NONE;
      rate_r       <= 6'd0;
      rcv_enough_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      prev_type_r  <= prev_type_nxt_s;
      prev_match_r <= prev_match_nxt_s;
      type_r       <= type_nxt_s;
      rate_r       <= rate_nxt_s;
      rcv_enough_r <= enough_nxt_s;
      ready_r      <= enough_nxt_s & bus.to_tsa_ts_sent_enough;
    end
  end

  assign prev_sym1_s = prev_match_r[39:32];
  assign prev_sym2_s = prev_match_r[31:24];
  assign lw_sub_s    = (ts_info[7:4] == ST_CFG) &&
                       ((ts_info[3:0] == SUB_CFG_LW_START) || (ts_info[3:0] == SUB_CFG_LW_ACC));
  assign ln_sub_s    = (ts_info[7:4] == ST_CFG) && (ts_info[3:0] == SUB_CFG_LN_WAIT);
  assign cnt_ge2_s   = (cnt_r >= CNT_W'(2)) && (prev_type_r == TS_TS1);
  assign link_go_s   = (mode == USP) && lw_sub_s && !link_done_r && cnt_ge2_s &&
                       (prev_sym1_s != PADG12) && (prev_sym2_s == PADG12);
  assign lane_go_s   = (mode == USP) && ln_sub_s && !lane_done_r && cnt_ge2_s &&
                       (prev_sym2_s != PADG12);

  // Handoff FSM: present one number to the generator until it acks; the done
  // flag keeps it from being resent until ts_info changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_state_r  <= HS_IDLE;
      link_num_r  <= 8'd0;
      lane_num_r  <= 8'd0;
      link_vld_r  <= 1'b0;
      lane_vld_r  <= 1'b0;
      link_done_r <= 1'b0;
      lane_done_r <= 1'b0;
    end else if (ts_info_update) begin
      hs_state_r  <= HS_IDLE;
      link_vld_r  <= 1'b0;
      lane_vld_r  <= 1'b0;
      link_done_r <= 1'b0;
      lane_done_r <= 1'b0;
    end else begin
      case (hs_state_r)
        HS_IDLE: begin
          if (link_go_s) begin
            link_num_r <= prev_sym1_s;
            link_vld_r <= 1'b1;
            hs_state_r <= HS_LINK_VLD;
          end else if (lane_go_s) begin
            lane_num_r <= prev_sym2_s;
            lane_vld_r <= 1'b1;
            hs_state_r <= HS_LANE_VLD;
          end
        end
        HS_LINK_VLD: begin
          if (bus.to_tsa_update_ack) begin
            link_vld_r  <= 1'b0;
            link_done_r <= 1'b1;
            hs_state_r  <= HS_IDLE;
          end
        end
        HS_LANE_VLD: begin
          if (bus.to_tsa_update_ack) begin
            lane_vld_r  <= 1'b0;
            lane_done_r <= 1'b1;
            hs_state_r  <= HS_IDLE;
          end
        end
        default: begin
          link_vld_r <= 1'b0;
          lane_vld_r <= 1'b0;
          hs_state_r <= HS_IDLE;
        end
      endcase
    end
  end

  assign bus.from_tsa_rcv_link_num     = link_num_r;
  assign bus.from_tsa_rcv_link_num_vld = link_vld_r;
  assign bus.from_tsa_rcv_lane_num     = lane_num_r;
  assign bus.from_tsa_rcv_lane_num_vld = lane_vld_r;
  assign rx_ts_type       = type_r;
  assign rx_consec_cnt    = cnt_r;
  assign rx_rate          = rate_r;
  assign rcv_enough       = rcv_enough_r;
  assign ready_to_advance = ready_r;

endmodule
